// File: rtl/ro_mux_scan_ctrl.sv
// rtl/ro_mux_scan_ctrl.sv - ring-oscillator mux scan controller with gated edge counting
//
// Steps the 16:1 ring-oscillator mux select through the sources enabled in
// src_mask_i. After each select change it waits SETTLE_CYCLES clocks, then
// counts rising edges of the synchronized mux output for gate_len clocks and
// hands one result per source to the consumer over a valid/ready handshake.
//
// Optional feature macro: RO_SCAN_CONTINUOUS_EN
//   defined   - while start_i stays high, the scan wraps around to the first
//               enabled source instead of finishing
//   undefined - one pass over the mask per start
//
// Ports:
//   wb_clk_i     clock
//   wb_rst_i     synchronous active-high reset
//   start_i      start request (level, sampled in IDLE)
//   src_mask_i   source enable mask, latched at start
//   gate_len_i   gate window in clocks, latched at start (0 acts as 1)
//   mux_y_i      asynchronous mux output
//   mux_sel_o    mux select
//   busy_o       controller not idle
//   res_valid_o  result valid
//   res_ready_i  result consumer ready
//   res_src_o    source index of the result
//   res_count_o  rising edges counted in the gate window
//   res_ovf_o    count saturated
//   done_o       one-cycle pulse on return to IDLE

module ro_mux_scan_ctrl #(
    parameter int N_SRC         = 16,
    parameter int SEL_W         = 4,
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [N_SRC-1:0]  src_mask_i,
    input  logic [GATE_W-1:0] gate_len_i,
    input  logic              mux_y_i,
    output logic [SEL_W-1:0]  mux_sel_o,
    output logic              busy_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [SEL_W-1:0]  res_src_o,
    output logic [CNT_W-1:0]  res_count_o,
    output logic              res_ovf_o,
    output logic              done_o
);

    localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_GATE,
        S_REPORT
    } state_t;

    state_t            state_q;
    logic [N_SRC-1:0]  pend_q;
`ifdef RO_SCAN_CONTINUOUS_EN
    logic [N_SRC-1:0]  mask_q;
`endif
    logic [GATE_W-1:0] gate_q;
    logic [ST_W-1:0]   settle_q;
    logic [GATE_W-1:0] gcnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [SEL_W-1:0]  sel_q;
    logic              busy_q;
    logic              valid_q;
    logic [SEL_W-1:0]  rsrc_q;
    logic [CNT_W-1:0]  rcnt_q;
    logic              rovf_q;
    logic              done_q;

    // Two flops to resynchronize the oscillator output, a third for edge detect.
    logic sync1_q, sync2_q, sync3_q;
    logic y_rise;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= mux_y_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign y_rise = sync2_q & ~sync3_q;

    // Sources still to visit in this SELECT; in continuous mode an exhausted
    // pass is refilled from the latched mask while start_i is held.
    logic [N_SRC-1:0] scan_v;
    logic [N_SRC-1:0] low_bit;
    logic [SEL_W-1:0] low_idx;

    always_comb begin
        scan_v = pend_q;
`ifdef RO_SCAN_CONTINUOUS_EN
        if (pend_q == '0 && start_i) begin
            scan_v = mask_q;
        end
`endif
        low_bit = scan_v & (~scan_v + N_SRC'(1));
        low_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (scan_v[i]) begin
                low_idx = SEL_W'(i);
            end
        end
    end

    // Saturating edge count: an edge arriving at all-ones is lost and flagged.
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;

    always_comb begin
        cnt_inc = cnt_q;
        ovf_inc = ovf_q;
        if (y_rise) begin
            if (&cnt_q) begin
                ovf_inc = 1'b1;
            end else begin
                cnt_inc = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
`ifdef RO_SCAN_CONTINUOUS_EN
            mask_q   <= '0;
`endif
            gate_q   <= GATE_W'(1);
            settle_q <= '0;
            gcnt_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            rsrc_q   <= '0;
            rcnt_q   <= '0;
            rovf_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pend_q <= src_mask_i;
`ifdef RO_SCAN_CONTINUOUS_EN
                        mask_q <= src_mask_i;
`endif
                        gate_q  <= (gate_len_i == '0) ? GATE_W'(1) : gate_len_i;
                        busy_q  <= 1'b1;
                        state_q <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (scan_v == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        sel_q    <= low_idx;
                        pend_q   <= scan_v & ~low_bit;
                        settle_q <= ST_W'(SETTLE_CYCLES - 1);
                        state_q  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        gcnt_q  <= gate_q - GATE_W'(1);
                        state_q <= S_GATE;
                    end else begin
                        settle_q <= settle_q - ST_W'(1);
                    end
                end
                S_GATE: begin
                    cnt_q <= cnt_inc;
                    ovf_q <= ovf_inc;
                    if (gcnt_q == '0) begin
                        // Include the last gate cycle's edge in the result.
                        rsrc_q  <= sel_q;
                        rcnt_q  <= cnt_inc;
                        rovf_q  <= ovf_inc;
                        valid_q <= 1'b1;
                        state_q <= S_REPORT;
                    end else begin
                        gcnt_q <= gcnt_q - GATE_W'(1);
                    end
                end
                S_REPORT: begin
                    if (res_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= S_SELECT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mux_sel_o   = sel_q;
    assign busy_o      = busy_q;
    assign res_valid_o = valid_q;
    assign res_src_o   = rsrc_q;
    assign res_count_o = rcnt_q;
    assign res_ovf_o   = rovf_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_ro_mux_scan_ctrl.sv
// tb/tb_ro_mux_scan_ctrl.sv - randomized self-checking bench for ro_mux_scan_ctrl
module tb_ro_mux_scan_ctrl;

    localparam int SETTLE = 8;
    localparam int MAXC   = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] mask;
    logic [15:0] gate;
    logic        y = 1'b0;
    logic        ready;

    logic [3:0]  sel, src, sel4, src4;
    logic        busy, valid, ovf, done;
    logic        busy4, valid4, ovf4, done4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    ro_mux_scan_ctrl #(.CNT_W(16), .SETTLE_CYCLES(SETTLE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .src_mask_i(mask),
        .gate_len_i(gate), .mux_y_i(y), .mux_sel_o(sel), .busy_o(busy),
        .res_valid_o(valid), .res_ready_i(ready), .res_src_o(src),
        .res_count_o(cnt), .res_ovf_o(ovf), .done_o(done)
    );

    ro_mux_scan_ctrl #(.CNT_W(4), .SETTLE_CYCLES(SETTLE)) dut_sat (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .src_mask_i(mask),
        .gate_len_i(gate), .mux_y_i(y), .mux_sel_o(sel4), .busy_o(busy4),
        .res_valid_o(valid4), .res_ready_i(ready), .res_src_o(src4),
        .res_count_o(cnt4), .res_ovf_o(ovf4), .done_o(done4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    bit yh [0:MAXC-1];
    int checks = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) y = yh[(cyc + 1) % MAXC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, 32'(sel), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_src"}, 32'(src), 0);
        check({tag, "_cnt"}, 32'(cnt), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    // ymode 0: random waveform, ymode P>0: square wave of period P clocks.
    task automatic fill_y(input int ymode);
        for (int n = cyc + 1; n < cyc + 4000 && n < MAXC; n++) begin
            if (ymode == 0) yh[n] = 1'($urandom_range(0, 1));
            else            yh[n] = ((n % ymode) < (ymode / 2));
        end
    endtask

    // Drive one scan and check every result against the timing/counting rules:
    // first select change at start+1, each result SETTLE+G clocks after its
    // select change, next select change the clock after the handshake.
    task automatic do_scan(input logic [15:0] m, input logic [15:0] g, input int ymode,
                           input int stall_max, input int npass);
        int k, tsel, tv, last, gl, e, nres, r, last_src;
        int srcs[$];
        fill_y(ymode);
        start = 1'b1; mask = m; gate = g;
        step();
        k = cyc;
        if (npass == 1) start = 1'b0;
        mask = 16'($urandom);
        gate = 16'($urandom);
        for (int p = 0; p < npass; p++)
            for (int i = 0; i < 16; i++)
                if (m[i]) srcs.push_back(i);
        nres = srcs.size();
        gl = (g == 0) ? 1 : int'(g);
        tsel = k + 1;
        last = k;
        last_src = -1;
        for (int idx = 0; idx < nres; idx++) begin
            tv = tsel + SETTLE + gl;
            while (cyc < tv) begin
                check("busy_scan", 32'(busy), 1);
                check("valid_early", 32'(valid), 0);
`ifndef RO_SCAN_CONTINUOUS_EN
                start = 1'($urandom_range(0, 1));
`endif
                step();
            end
            start = (npass > 1 && idx + 1 < nres);
            e = 0;
            for (int n = tsel + SETTLE + 1; n <= tv; n++)
                e += (yh[n - 2] && !yh[n - 3]) ? 1 : 0;
            check("valid", 32'(valid), 1);
            check("src", 32'(src), srcs[idx]);
            check("sel", 32'(sel), srcs[idx]);
            check("count16", 32'(cnt), (e > 65535) ? 65535 : e);
            check("ovf16", 32'(ovf), 32'(e > 65535));
            check("count4", 32'(cnt4), (e > 15) ? 15 : e);
            check("ovf4", 32'(ovf4), 32'(e > 15));
            check("done_mid", 32'(done), 0);
            r = $urandom_range(0, stall_max);
            ready = 1'b0;
            for (int s = 0; s < r; s++) begin
                step();
                check("stall_valid", 32'(valid), 1);
                check("stall_src", 32'(src), srcs[idx]);
                check("stall_cnt4", 32'(cnt4), (e > 15) ? 15 : e);
                check("stall_sel", 32'(sel), srcs[idx]);
            end
            ready = 1'b1;
            step();
            ready = 1'b0;
            check("valid_after_hs", 32'(valid), 0);
            tsel = cyc + 1;
            last = cyc;
            last_src = srcs[idx];
        end
        while (cyc < last + 1) step();
        check("done", 32'(done), 1);
        check("busy_done", 32'(busy), 0);
        check("valid_done", 32'(valid), 0);
        if (last_src >= 0) check("sel_hold", 32'(sel), last_src);
        step();
        check("done_one_cycle", 32'(done), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mask = '0; gate = '0; ready = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst_init");
        rst = 1'b0;
        step();
        check_reset_outputs("idle_init");

        // Single source, square wave period 4 over 40 clocks.
        do_scan(16'h0004, 16'd40, 4, 0, 1);
        // Ordering 0, 8, 15 with back-pressure.
        do_scan(16'h8101, 16'd20, 0, 5, 1);
        // Empty mask.
        do_scan(16'h0000, 16'd5, 0, 0, 1);
        // Saturation on the 4-bit instance.
        do_scan(16'h0020, 16'd100, 2, 1, 1);
        // Gate length 0 behaves as 1.
        do_scan(16'h0401, 16'd0, 0, 2, 1);
        for (int t = 0; t < 5; t++)
            do_scan(16'($urandom), 16'($urandom_range(0, 24)), 0, 3, 1);
`ifdef RO_SCAN_CONTINUOUS_EN
        do_scan(16'h0003, 16'd10, 0, 2, 3);
`endif

        // Reset mid-GATE aborts without result or done.
        fill_y(4);
        start = 1'b1; mask = 16'h0004; gate = 16'd40;
        step();
        start = 1'b0;
        repeat (SETTLE + 6) step();
        check("busy_pre_rst", 32'(busy), 1);
        rst = 1'b1;
        step();
        step();
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            check("post_rst_valid", 32'(valid), 0);
            check("post_rst_done", 32'(done), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
